// File: rtl/mem_config_mq.sv
// mem_config_mq: per-stream buffer descriptor FIFOs loaded over a config write bus,
// with masked flush, occupancy/overflow status readback and sticky clear-on-read overflow.
module mem_config_mq #(
  parameter int          NUM_STREAMS = 4,
  parameter int          FIFO_DEPTH  = 64,
  parameter int          ADDR_BITS   = 64,
  parameter int          LEN_BITS    = 32,
  parameter int          DATA_BITS   = 64,
  parameter int          REG_BITS    = 8,
  parameter logic [31:0] CONFIG_ID   = 32'h4D51_0002
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_valid,
  input  logic [REG_BITS-1:0]              wr_addr,
  input  logic [DATA_BITS-1:0]             wr_data,
  input  logic                             rd_valid,
  input  logic [REG_BITS-1:0]              rd_addr,
  output logic [DATA_BITS-1:0]             rd_data,
  output logic                             rd_data_valid,
  output logic [NUM_STREAMS-1:0]           buf_valid,
  input  logic [NUM_STREAMS-1:0]           buf_ready,
  output logic [NUM_STREAMS*ADDR_BITS-1:0] buf_addr,
  output logic [NUM_STREAMS*LEN_BITS-1:0]  buf_len,
  output logic [NUM_STREAMS-1:0]           flush
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic                 r_rst;
  logic                 w_flush_wr;
  logic [DATA_BITS-1:0] w_rd;
  logic [DATA_BITS-1:0] w_stat [NUM_STREAMS];
  always_ff @(posedge clk) r_rst <= ~rst_n;
  assign w_flush_wr = wr_valid && wr_addr == REG_BITS'(2 * NUM_STREAMS);
  for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_s
    logic [ADDR_BITS+LEN_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_BITS-1:0]          r_stage;
    logic [PW-1:0]                 r_wp, r_rp;
    logic [CW-1:0]                 r_cnt;
    logic                          r_ovf, r_flush;
    logic                          w_pop, w_commit, w_push, w_fl, w_clr;
    assign w_pop    = (r_cnt != '0) && buf_ready[i];
    assign w_commit = wr_valid && wr_addr == REG_BITS'(2 * i + 1);
    // a full FIFO still takes a commit when the head leaves on the same edge
    assign w_push   = w_commit && (r_cnt != CW'(FIFO_DEPTH) || w_pop);
    assign w_fl     = w_flush_wr && wr_data[i];
    assign w_clr    = rd_valid && rd_addr == REG_BITS'(3 + i);
    always_ff @(posedge clk) begin
      if (r_rst) begin
        r_stage <= '0;
        r_wp    <= '0;
        r_rp    <= '0;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
        r_flush <= 1'b0;
      end else begin
        r_flush <= w_fl;
        r_ovf   <= (w_commit && !w_push) || (r_ovf && !w_clr);
        if (w_fl) begin
          r_stage <= '0;
          r_wp    <= '0;
          r_rp    <= '0;
          r_cnt   <= '0;
        end else begin
          if (wr_valid && wr_addr == REG_BITS'(2 * i)) r_stage <= wr_data[ADDR_BITS-1:0];
          if (w_push) r_wp <= r_wp + PW'(1);
          if (w_pop) r_rp <= r_rp + PW'(1);
          r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
      end
    end
    always_ff @(posedge clk) if (w_push) r_mem[r_wp] <= {r_stage, wr_data[LEN_BITS-1:0]};
    assign buf_valid[i] = r_cnt != '0;
    assign {buf_addr[i*ADDR_BITS +: ADDR_BITS], buf_len[i*LEN_BITS +: LEN_BITS]} = r_mem[r_rp];
    assign flush[i]     = r_flush;
    assign w_stat[i]    = DATA_BITS'({r_ovf, 15'b0, 16'(r_cnt)});
  end
  always_comb begin
    w_rd = '0;
    if (rd_addr == REG_BITS'(0)) w_rd = DATA_BITS'(CONFIG_ID);
    if (rd_addr == REG_BITS'(1)) w_rd = DATA_BITS'(NUM_STREAMS);
    if (rd_addr == REG_BITS'(2)) w_rd = DATA_BITS'(FIFO_DEPTH);
    for (int k = 0; k < NUM_STREAMS; k++) if (rd_addr == REG_BITS'(3 + k)) w_rd = w_stat[k];
  end
  always_ff @(posedge clk) begin
    if (r_rst) begin
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
    end else begin
      rd_data_valid <= rd_valid;
      if (rd_valid) rd_data <= w_rd;
    end
  end
endmodule

// File: tb/tb_mem_config_mq.sv
// tb_mem_config_mq: directed and random stimulus checked cycle by cycle against a
// queue-based descriptor model of the configuration block.
module tb_mem_config_mq;
  localparam int NS = 4, DEPTH = 64;
  logic         clk = 0, rst_n = 0, wr_valid = 0, rd_valid = 0;
  logic [7:0]   wr_addr = 0, rd_addr = 0;
  logic [63:0]  wr_data = 0, rd_data;
  logic         rd_data_valid;
  logic [3:0]   buf_valid, flush, buf_ready = 0;
  logic [255:0] buf_addr;
  logic [127:0] buf_len;
  int vectors = 0, miscompares = 0;
  logic [95:0] q [NS][$];
  logic [63:0] stage [NS];
  logic        ovf [NS];
  logic [3:0]  m_flush;
  logic [63:0] m_rd;
  logic        m_rdv;

  mem_config_mq dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .buf_valid(buf_valid), .buf_ready(buf_ready), .buf_addr(buf_addr), .buf_len(buf_len),
    .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] reg_val(input logic [7:0] a);
    if (a == 0) return 64'h4D51_0002;
    if (a == 1) return NS;
    if (a == 2) return DEPTH;
    if (a >= 3 && a < 3 + NS) return {32'b0, ovf[a-3], 15'b0, 16'(q[a-3].size())};
    return 0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      q[s].delete();
      stage[s] = 0;
      ovf[s] = 0;
    end
    m_flush = 0;
    m_rd = 0;
    m_rdv = 0;
  endtask

  task automatic check_outputs();
    chk("rd_data_valid", rd_data_valid, m_rdv);
    chk("rd_data", rd_data, m_rd);
    chk("flush", flush, m_flush);
    for (int s = 0; s < NS; s++) begin
      chk($sformatf("buf_valid[%0d]", s), buf_valid[s], q[s].size() != 0);
      if (q[s].size() > 0) begin
        chk($sformatf("buf_addr[%0d]", s), buf_addr[s*64 +: 64], q[s][0][95:32]);
        chk($sformatf("buf_len[%0d]", s), buf_len[s*32 +: 32], q[s][0][31:0]);
      end
    end
  endtask

  task automatic step(input logic wv, input logic [7:0] wa, input logic [63:0] wd,
                      input logic rv, input logic [7:0] ra, input logic [3:0] rdy);
    int s;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra; buf_ready = rdy;
    m_rdv = rv;
    if (rv) m_rd = reg_val(ra);
    for (int k = 0; k < NS; k++) if (rv && ra == 3 + k) ovf[k] = 0;
    m_flush = 0;
    for (int k = 0; k < NS; k++) if (rdy[k] && q[k].size() > 0) void'(q[k].pop_front());
    if (wv && wa < 2 * NS) begin
      s = int'(wa) / 2;
      if (wa[0]) begin
        if (q[s].size() < DEPTH) q[s].push_back({stage[s], wd[31:0]});
        else ovf[s] = 1;
      end else stage[s] = wd;
    end else if (wv && wa == 2 * NS) begin
      for (int k = 0; k < NS; k++) if (wd[k]) begin
        q[k].delete();
        stage[k] = 0;
        m_flush[k] = 1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [7:0] wa, ra;
    logic [63:0] wd;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    idle();
    chk("reset_buf_valid", buf_valid, 4'b0000);
    // basic commit, pop and status
    step(1, 0, 64'h1000_0000_0040, 0, 0, 0);
    step(1, 1, 64'h200, 0, 0, 0);
    chk("basic_addr", buf_addr[63:0], 64'h1000_0000_0040);
    chk("basic_len", buf_len[31:0], 64'h200);
    step(0, 0, 0, 0, 0, 4'b0001);
    step(0, 0, 0, 1, 3, 0);
    chk("basic_status", rd_data, 64'h0);
    // overflow on stream 1, then clear-on-read
    step(1, 2, {$urandom, $urandom}, 0, 0, 0);
    for (int i = 0; i < 65; i++) step(1, 3, 64'($urandom), 0, 0, 0);
    step(0, 0, 0, 1, 4, 0);
    chk("ovf_status", rd_data, 64'h8000_0040);
    step(0, 0, 0, 1, 4, 0);
    chk("ovf_cleared", rd_data, 64'h40);
    // full FIFO with simultaneous pop accepts the commit
    step(1, 3, 64'hABCD, 0, 0, 4'b0010);
    step(0, 0, 0, 1, 4, 0);
    chk("full_pop_status", rd_data, 64'h40);
    step(1, 8, 64'h2, 0, 0, 0);
    idle();
    // masked flush of stream 2 only
    step(1, 0, 64'hA000, 0, 0, 0);
    step(1, 4, 64'hC000, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 64'(i + 1), 0, 0, 0);
      step(1, 5, 64'(i + 11), 0, 0, 0);
    end
    step(1, 8, 64'h4, 0, 0, 0);
    chk("mflush_pulse", flush, 4'b0100);
    step(0, 0, 0, 1, 5, 0);
    chk("mflush_once", flush, 4'b0000);
    chk("mflush_s2_status", rd_data, 64'h0);
    step(0, 0, 0, 1, 3, 0);
    chk("mflush_s0_status", rd_data, 64'h3);
    repeat (3) step(0, 0, 0, 0, 0, 4'b0001);
    // reset with descriptors queued
    step(1, 6, 64'h3333_0000, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 7, 64'(i), 0, 0, 0);
    rst_n = 0;
    idle();
    rst_n = 1;
    model_reset();
    idle();
    chk("rst_buf_valid", buf_valid, 4'b0000);
    chk("rst_flush", flush, 4'b0000);
    step(0, 0, 0, 1, 0, 0);
    chk("rst_id", rd_data, 64'h4D51_0002);
    step(0, 0, 0, 1, 1, 0);
    chk("rst_ns", rd_data, 64'd4);
    step(0, 0, 0, 1, 6, 0);
    chk("rst_s3_status", rd_data, 64'h0);
    // pointer wrap with commit/pop pairs
    step(1, 0, 64'h5555_0000_0000, 0, 0, 0);
    for (int i = 0; i < 200; i++) step(1, 1, 64'(i), 0, 0, 4'b0001);
    step(0, 0, 0, 1, 3, 0);
    chk("wrap_status", rd_data, 64'h1);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      wa = 8'($urandom_range(0, 9));
      ra = 8'($urandom_range(0, 12));
      wd = (wa == 8) ? 64'($urandom_range(0, 15)) : {$urandom, $urandom};
      step(1'($urandom), wa, wd, 1'($urandom), ra,
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
